// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion. Produces one 32-bit word per GEN
// cycle, takes SBOX_LAT extra cycles before each word that needs SubWord, and
// streams 128-bit round keys over a one-deep valid/ready output slot.
module aes_key_schedule #(
  parameter int KEY_W    = 256,
  parameter int SBOX_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] key_in,
  input  logic             abort,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SUB, GEN, DRAIN} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] win_q [8];      // win_q[0] = w[i-1], win_q[k-1] = w[i-k]
  logic [31:0] key_word [8];
  logic [5:0]  i_q;            // index of the word produced in the current GEN cycle
  logic [2:0]  phase_q;        // i mod Nk, kept incrementally
  logic [5:0]  nk_q, nk_sel;
  logic [7:0]  rcon_q;
  logic [31:0] sub_w, temp, w_new;
  logic [2:0]  phase_nxt;
  logic        key_phase, is_rot, is_sub_only, group_end, advance, last_word, need_sbox_nxt;
  logic        start_ok;

  // Split the MSB-aligned key into words and decode the requested key length.
  always_comb begin
    for (int j = 0; j < 8; j++) key_word[j] = key_in[KEY_W-1-32*j -: 32];
    case (key_len)
      2'b01:   nk_sel = 6'd6;
      2'b10:   nk_sel = 6'd8;
      default: nk_sel = 6'd4;
    endcase
  end

  // SubWord of the newest word: a registered ROM read, or combinational for SBOX_LAT=0.
  generate
    if (SBOX_LAT == 1) begin : g_sbox_reg
      logic [31:0] sub_q;
      // Window is stalled during SUB and stalls, so sub_q always matches win_q[0] in GEN.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sub_q <= '0;
        else          sub_q <= sub_word(win_q[0]);
      end
      assign sub_w = sub_q;
    end else begin : g_sbox_comb
      assign sub_w = sub_word(win_q[0]);
    end
  endgenerate

  // Word generation, group/stall control and next-state decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    start_ok      = (state_q == IDLE) && start && (key_len != 2'b11);
    key_phase     = (i_q < nk_q);
    is_rot        = !key_phase && (phase_q == 3'd0);
    is_sub_only   = !key_phase && (nk_q == 6'd8) && (phase_q == 3'd4);
    temp          = is_rot      ? ({sub_w[23:0], sub_w[31:24]} ^ {rcon_q, 24'h0}) :
                    is_sub_only ? sub_w : win_q[0];
    // During the key phase the window was preloaded so win_q[Nk-1] is key word i.
    w_new         = key_phase ? win_q[3'(nk_q - 6'd1)] : (win_q[3'(nk_q - 6'd1)] ^ temp);
    group_end     = (i_q[1:0] == 2'b11);
    advance       = (state_q == GEN) && (!group_end || !rk_valid || rk_ready);
    last_word     = (i_q == (nk_q << 2) + 6'd27);
    phase_nxt     = (phase_q == 3'(nk_q - 6'd1)) ? 3'd0 : phase_q + 3'd1;
    need_sbox_nxt = (phase_nxt == 3'd0) ||
                    ((nk_q == 6'd8) && (phase_nxt == 3'd4) && (i_q >= 6'd7));
    case (state_q)
      IDLE:  if (start_ok) state_d = GEN;
      SUB:   state_d = GEN;
      GEN:   if (advance) begin
               if (last_word)                            state_d = DRAIN;
               else if (need_sbox_nxt && SBOX_LAT == 1)  state_d = SUB;
             end
      DRAIN: if (rk_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word window, counters and Rcon: load on start, shift on each produced word.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the window is a plain register bank, not a RAM, so clearing it on reset is cheap and safe.
    if (!reset_n) begin
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
      i_q     <= '0;
      phase_q <= '0;
      nk_q    <= 6'd4;
      rcon_q  <= '0;
    end else if (start_ok && !abort) begin
      for (int j = 0; j < 8; j++)
        win_q[j] <= (j < int'(nk_sel)) ? key_word[3'(int'(nk_sel) - 1 - j)] : '0;
      i_q     <= '0;
      phase_q <= '0;
      nk_q    <= nk_sel;
      rcon_q  <= 8'h01;
    end else if (advance) begin
      // NOTE: non-blocking assignments make every stage read the old value, giving a true shift.
      win_q[0] <= w_new;
      for (int j = 1; j < 8; j++) win_q[j] <= win_q[j-1];
      i_q     <= i_q + 6'd1;
      phase_q <= phase_nxt;
      if (is_rot) rcon_q <= xtime(rcon_q);
    end
  end

  // One-deep output slot: load a finished group, clear on accept, drop on abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_data  <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= (state_q == IDLE) && start && (key_len == 2'b11) && !abort;
      if (abort) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end else if (advance && group_end) begin
        rk_data  <= {win_q[2], win_q[1], win_q[0], w_new};
        rk_round <= i_q[5:2];
        rk_valid <= 1'b1;
        rk_last  <= last_word;
      end else if (rk_ready) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: known-answer keys for all three modes,
// latency, backpressure, illegal key length, ignored start, abort and reset.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         abort;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [7:0] RCON_TAB [11] =
    '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_key_schedule dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .abort    (abort),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_last  (rk_last),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = TB_SBOX[(255 - int'(w[8*k +: 8])) * 8 +: 8];
    return r;
  endfunction

  // Textbook key expansion over a flat word array, filling exp_rk.
  task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0)              t = tb_subw({t[23:0], t[31:24]}) ^ {RCON_TAB[i/nk], 24'h0};
        else if (nk > 6 && i % nk == 4) t = tb_subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 15; r++)
      exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One run: start, collect keys under the given ready duty, optionally cut it short.
  task automatic run_key(input string name, input logic [1:0] kl, input logic [255:0] key,
                         input int ready_pct, input int exp_first, input int exp_last,
                         input int cut_round, input bit cut_reset, input int dup_cyc);
    int nr, cyc, got, first_cyc, last_cyc;
    bit hold, done;
    logic [127:0] hold_data;
    nr = 10 + 2 * int'(kl);
    model_expand(kl, key);
    @(negedge clk);
    start    = 1'b1;
    key_len  = kl;
    key_in   = key;
    rk_ready = ($urandom_range(99) < ready_pct);
    @(posedge clk);
    cyc = 0; got = 0; first_cyc = -1; last_cyc = -1; hold = 1'b0; done = 1'b0; hold_data = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      if (hold) begin
        check({name, "_hold_valid"}, 128'(rk_valid), 128'(1));
        check({name, "_hold_data"}, rk_data, hold_data);
      end
      if (rk_valid && first_cyc < 0) first_cyc = cyc;
      if (cut_round >= 0 && rk_valid && rk_round == 4'(cut_round)) begin
        if (cut_reset) begin
          reset_n = 1'b0;
          #1;
          check({name, "_rst_valid"}, 128'(rk_valid), 128'(0));
          check({name, "_rst_busy"},  128'(busy),     128'(0));
          check({name, "_rst_last"},  128'(rk_last),  128'(0));
          check({name, "_rst_data"},  rk_data,        128'(0));
          @(negedge clk);
          reset_n = 1'b1;
        end else begin
          abort    = 1'b1;
          rk_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check({name, "_abort_valid"}, 128'(rk_valid), 128'(0));
          check({name, "_abort_busy"},  128'(busy),     128'(0));
          check({name, "_abort_last"},  128'(rk_last),  128'(0));
        end
        return;
      end
      if (cyc == dup_cyc) begin
        start   = 1'b1;
        key_len = 2'b10;
        key_in  = {8{32'hdeadbeef}};
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid && rk_ready) begin
        check({name, "_data"},  rk_data,           exp_rk[got]);
        check({name, "_round"}, 128'(rk_round),    128'(got));
        check({name, "_last"},  128'(rk_last),     128'(got == nr));
        got_rk[got] = rk_data;
        if (got == nr) begin
          last_cyc = cyc;
          done     = 1'b1;
        end
        got++;
      end
      hold      = rk_valid && !rk_ready;
      hold_data = rk_data;
      cyc++;
    end
    check({name, "_key_count"}, 128'(got), 128'(nr + 1));
    if (exp_first >= 0) check({name, "_first_lat"}, 128'(first_cyc), 128'(exp_first));
    if (exp_last  >= 0) check({name, "_last_lat"},  128'(last_cyc),  128'(exp_last));
    @(negedge clk);
    start = 1'b0;
    check({name, "_end_busy"},  128'(busy),     128'(0));
    check({name, "_end_valid"}, 128'(rk_valid), 128'(0));
    rk_ready = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    key_len  = 2'b00;
    key_in   = '0;
    abort    = 1'b0;
    rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 128'(rk_valid), 128'(0));
    check("reset_busy",  128'(busy),     128'(0));
    check("reset_err",   128'(err),      128'(0));
    check("reset_last",  128'(rk_last),  128'(0));
    check("reset_round", 128'(rk_round), 128'(0));
    check("reset_data",  rk_data,        128'(0));
    reset_n = 1'b1;

    // Known-answer runs with the consumer always ready.
    run_key("aes128", 2'b00, KEY128, 100, 4, 54, -1, 1'b0, -1);
    check("aes128_r0",  got_rk[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("aes128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key("aes192", 2'b01, KEY192, 100, 4, 60, -1, 1'b0, -1);
    check("aes192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    run_key("aes256", 2'b10, KEY256, 100, 4, 73, -1, 1'b0, -1);
    check("aes256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Backpressure at roughly 30% ready duty.
    run_key("bp128", 2'b00, KEY128, 30, -1, -1, -1, 1'b0, -1);
    run_key("bp192", 2'b01, KEY192, 30, -1, -1, -1, 1'b0, -1);
    run_key("bp256", 2'b10, KEY256, 30, -1, -1, -1, 1'b0, -1);
    check("bp256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Illegal key length: one-cycle err, no run.
    @(negedge clk);
    start   = 1'b1;
    key_len = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("illegal_err",   128'(err),      128'(1));
    check("illegal_busy",  128'(busy),     128'(0));
    check("illegal_valid", 128'(rk_valid), 128'(0));
    @(negedge clk);
    check("illegal_err_pulse", 128'(err), 128'(0));

    // A start during a run is ignored and raises no err.
    run_key("dupstart", 2'b00, KEY128, 100, 4, 54, -1, 1'b0, 20);

    // Abort at round 5 of AES-256, then a clean AES-128 run.
    run_key("abort256", 2'b10, KEY256, 100, -1, -1, 5, 1'b0, -1);
    run_key("after_abort", 2'b00, KEY128, 100, 4, 54, -1, 1'b0, -1);

    // Reset pulsed at round 5 of AES-256, then a clean AES-128 run.
    run_key("rst256", 2'b10, KEY256, 100, -1, -1, 5, 1'b1, -1);
    run_key("after_rst", 2'b00, KEY128, 100, 4, 54, -1, 1'b0, -1);
    check("after_rst_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
